// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and constants for the SPI master that drives the SPI slave / RAM subsystem.
// One frame is a 2-bit control code followed by an 8-bit payload, MSB first.
package spi_master_ctrl_pkg;

    localparam int MEM_WIDTH  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } control_e;

    typedef enum logic [2:0] {
        M_IDLE,
        M_SETUP,
        M_SHIFT,
        M_TURN,
        M_RECV,
        M_HOLD,
        M_GUARD
    } master_state_e;

    // States during which ss_n is held low.
    function automatic logic frame_active(master_state_e s);
        return s inside {M_SETUP, M_SHIFT, M_TURN, M_RECV, M_HOLD};
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side command/response bus of the SPI master.
// The host uses the master modport; the SPI master block uses the slave modport.
interface spi_master_ctrl_if;
    import spi_master_ctrl_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    control_e             cmd_ctrl;
    logic [MEM_WIDTH-1:0] cmd_data;
    logic                 rsp_valid;
    logic [MEM_WIDTH-1:0] rsp_data;
    logic                 busy;

    modport master (
        output cmd_valid, cmd_ctrl, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_ctrl, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/spi_master_ctrl_sclk_gen.sv
// SCLK generator: half-period divider plus one-cycle strobes marking the clk edge on
// which sclk rises or falls. Counting and toggling are enabled separately by the FSM.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_en,
    input  logic sclk_en,
    output logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;

    assign tick = cnt_en && (div_cnt == DIV_LAST);
    assign rise = tick && sclk_en && !sclk;
    assign fall = tick && sclk_en && sclk;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!cnt_en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            if (!sclk_en)
                sclk <= 1'b0;
            else if (tick)
                sclk <= !sclk;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: turns one host command into one ss_n-framed transaction and,
// for RD_DATA, returns the byte shifted in on miso after the turnaround gap.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int TURN_BITS = 1,
    parameter int SS_GUARD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_master_ctrl_if.slave host,
    output logic             sclk,
    output logic             ss_n,
    output logic             mosi,
    input  logic             miso
);

    localparam logic [7:0] GUARD_LAST = 8'((SS_GUARD < 1 ? 1 : SS_GUARD) - 1);

    master_state_e        state, next_state;
    control_e             ctrl;
    logic [FRAME_BITS-1:0] sh;
    logic [MEM_WIDTH-1:0] rx;
    logic [7:0]           bit_cnt;
    logic [7:0]           guard_cnt;
    logic                 cnt_en, sclk_en;
    logic                 tick, rise, fall;
    logic                 hs;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_en  (cnt_en),
        .sclk_en (sclk_en),
        .sclk    (sclk),
        .tick    (tick),
        .rise    (rise),
        .fall    (fall)
    );

    assign hs = host.cmd_valid && host.cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= M_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            M_IDLE:  if (hs) next_state = M_SETUP;
            M_SETUP: if (tick) next_state = M_SHIFT;
            M_SHIFT:
                if (fall && bit_cnt == 8'(FRAME_BITS)) begin
                    if (ctrl != RD_DATA)
                        next_state = M_HOLD;
                    else
                        next_state = (TURN_BITS == 0) ? M_RECV : M_TURN;
                end
            M_TURN:  if (fall && bit_cnt == 8'(TURN_BITS)) next_state = M_RECV;
            M_RECV:  if (fall && bit_cnt == 8'(MEM_WIDTH)) next_state = M_HOLD;
            M_HOLD:  if (tick) next_state = M_GUARD;
            M_GUARD: if (guard_cnt == GUARD_LAST) next_state = M_IDLE;
            default: next_state = M_IDLE;
        endcase
    end

    always_comb begin
        host.cmd_ready = (state == M_IDLE);
        host.busy      = (state != M_IDLE);
        cnt_en         = frame_active(state);
        sclk_en        = state inside {M_SHIFT, M_TURN, M_RECV};
    end

    // ss_n follows next_state so the pin is a clean flop that matches the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n           <= 1'b1;
            mosi           <= 1'b0;
            sh             <= '0;
            ctrl           <= WR_ADDR;
            rx             <= '0;
            bit_cnt        <= '0;
            guard_cnt      <= '0;
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
        end else begin
            ss_n           <= !frame_active(next_state);
            host.rsp_valid <= 1'b0;
            guard_cnt      <= (state == M_GUARD) ? guard_cnt + 8'd1 : 8'd0;

            // Each phase counts its own rising edges from zero.
            if (state != next_state)
                bit_cnt <= '0;
            else if (rise)
                bit_cnt <= bit_cnt + 8'd1;

            unique case (state)
                M_IDLE:
                    if (hs) begin
                        sh   <= {host.cmd_ctrl, host.cmd_data};
                        ctrl <= host.cmd_ctrl;
                        mosi <= host.cmd_ctrl[1];
                    end
                // Shifted-in zeros leave mosi low once the last frame bit has gone out.
                M_SHIFT:
                    if (fall) begin
                        sh   <= {sh[FRAME_BITS-2:0], 1'b0};
                        mosi <= sh[FRAME_BITS-2];
                    end
                M_RECV:
                    if (rise) rx <= {rx[MEM_WIDTH-2:0], miso};
                M_HOLD:
                    if (tick && ctrl == RD_DATA) begin
                        host.rsp_valid <= 1'b1;
                        host.rsp_data  <= rx;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: one instance at CLK_DIV=2 and one at CLK_DIV=1,
// each talking to a behavioural SPI slave + RAM model.
module tb_spi_master_ctrl;
    import spi_master_ctrl_pkg::*;

    localparam int TB_TURN = 1;
    localparam int BUDGET  = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    spi_master_ctrl_if bus0 ();
    spi_master_ctrl_if bus1 ();

    logic       h_valid [2];
    control_e   h_ctrl  [2];
    logic [7:0] h_data  [2];
    logic       o_ready [2];
    logic       o_busy  [2];
    logic       o_rsp_valid [2];
    logic [7:0] o_rsp_data  [2];
    logic       sclk_w [2];
    logic       ss_w   [2];
    logic       mosi_w [2];
    logic       miso_w [2];

    assign bus0.cmd_valid = h_valid[0];
    assign bus0.cmd_ctrl  = h_ctrl[0];
    assign bus0.cmd_data  = h_data[0];
    assign bus1.cmd_valid = h_valid[1];
    assign bus1.cmd_ctrl  = h_ctrl[1];
    assign bus1.cmd_data  = h_data[1];
    assign o_ready[0]     = bus0.cmd_ready;
    assign o_ready[1]     = bus1.cmd_ready;
    assign o_busy[0]      = bus0.busy;
    assign o_busy[1]      = bus1.busy;
    assign o_rsp_valid[0] = bus0.rsp_valid;
    assign o_rsp_valid[1] = bus1.rsp_valid;
    assign o_rsp_data[0]  = bus0.rsp_data;
    assign o_rsp_data[1]  = bus1.rsp_data;

    spi_master_ctrl #(.CLK_DIV(2), .TURN_BITS(TB_TURN), .SS_GUARD(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (bus0),
        .sclk  (sclk_w[0]),
        .ss_n  (ss_w[0]),
        .mosi  (mosi_w[0]),
        .miso  (miso_w[0])
    );

    spi_master_ctrl #(.CLK_DIV(1), .TURN_BITS(TB_TURN), .SS_GUARD(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (bus1),
        .sclk  (sclk_w[1]),
        .ss_n  (ss_w[1]),
        .mosi  (mosi_w[1]),
        .miso  (miso_w[1])
    );

    // Slave + RAM model and pin monitors, sampled away from the active edge.
    logic       sclk_p [2] = '{1'b0, 1'b0};
    logic       mosi_p [2] = '{1'b0, 1'b0};
    int         rises  [2] = '{0, 0};
    logic [8:0] shreg  [2] = '{9'd0, 9'd0};
    logic [9:0] frame_bits [2] = '{10'd0, 10'd0};
    int         frames [2] = '{0, 0};
    logic [7:0] wr_q   [2] = '{8'd0, 8'd0};
    logic [7:0] rd_q   [2] = '{8'd0, 8'd0};
    logic [7:0] out_q  [2] = '{8'd0, 8'd0};
    logic [7:0] ram    [2][256];
    int         low_run  [2] = '{0, 0};
    int         last_len [2] = '{0, 0};
    int         high_run [2] = '{0, 0};
    int         min_high [2] = '{1000, 1000};
    int         guard_run [2] = '{0, 0};
    int         rsp_cnt  [2] = '{0, 0};
    int         gap_cyc  [2] = '{0, 0};
    logic       have_rise [2] = '{1'b0, 1'b0};
    int         per_min  [2] = '{1000, 1000};
    int         per_max  [2] = '{0, 0};
    int         mosi_viol  [2] = '{0, 0};
    int         ready_viol [2] = '{0, 0};

    initial begin
        miso_w[0] = 1'b0;
        miso_w[1] = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int g = 0; g < 2; g++) begin
                sclk_p[g] <= sclk_w[g];
                mosi_p[g] <= mosi_w[g];
                if (o_rsp_valid[g] === 1'b1) rsp_cnt[g] <= rsp_cnt[g] + 1;
                if ((o_ready[g] === o_busy[g]) || (ss_w[g] === 1'b0 && o_ready[g] === 1'b1))
                    ready_viol[g] <= ready_viol[g] + 1;
                if (ss_w[g]) begin
                    rises[g]     <= 0;
                    miso_w[g]    <= 1'b0;
                    have_rise[g] <= 1'b0;
                    high_run[g]  <= high_run[g] + 1;
                    low_run[g]   <= 0;
                    if (low_run[g] != 0) last_len[g] <= low_run[g];
                    if (o_busy[g]) guard_run[g] <= guard_run[g] + 1;
                end else begin
                    low_run[g]   <= low_run[g] + 1;
                    guard_run[g] <= 0;
                    high_run[g]  <= 0;
                    if (high_run[g] != 0 && high_run[g] < min_high[g]) min_high[g] <= high_run[g];
                    if (sclk_w[g] && !sclk_p[g]) begin
                        rises[g]     <= rises[g] + 1;
                        have_rise[g] <= 1'b1;
                        gap_cyc[g]   <= 1;
                        if (mosi_w[g] !== mosi_p[g]) mosi_viol[g] <= mosi_viol[g] + 1;
                        if (have_rise[g]) begin
                            if (gap_cyc[g] < per_min[g]) per_min[g] <= gap_cyc[g];
                            if (gap_cyc[g] > per_max[g]) per_max[g] <= gap_cyc[g];
                        end
                        if (rises[g] < 10) shreg[g] <= {shreg[g][7:0], mosi_w[g]};
                        if (rises[g] == 9) begin
                            frame_bits[g] <= {shreg[g], mosi_w[g]};
                            frames[g]     <= frames[g] + 1;
                            case (control_e'(shreg[g][8:7]))
                                WR_ADDR: wr_q[g] <= {shreg[g][6:0], mosi_w[g]};
                                WR_DATA: ram[g][wr_q[g]] <= {shreg[g][6:0], mosi_w[g]};
                                RD_ADDR: rd_q[g] <= {shreg[g][6:0], mosi_w[g]};
                                RD_DATA: out_q[g] <= ram[g][rd_q[g]];
                                default: ;
                            endcase
                        end
                    end else begin
                        gap_cyc[g] <= gap_cyc[g] + 1;
                        if (!sclk_w[g] && sclk_p[g]) begin
                            if (rises[g] >= 10 + TB_TURN && rises[g] < 18 + TB_TURN)
                                miso_w[g] <= out_q[g][3'(17 + TB_TURN - rises[g])];
                            else
                                miso_w[g] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input int g, input control_e c, input logic [7:0] d);
        int n;
        @(negedge clk);
        h_ctrl[g]  = c;
        h_data[g]  = d;
        h_valid[g] = 1'b1;
        n = 0;
        while (o_ready[g] !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < BUDGET, 1'b1);
        @(posedge clk);
        #1 h_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        @(negedge clk);
        while (o_ready[g] !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", n < BUDGET, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        control_e   b_ctrl [3];
        logic [7:0] b_data [3];
        int         f0, r0, n;

        b_ctrl = '{WR_ADDR, WR_DATA, WR_ADDR};
        b_data = '{8'h11, 8'h5A, 8'h3C};
        for (int g = 0; g < 2; g++) begin
            h_valid[g] = 1'b0;
            h_ctrl[g]  = WR_ADDR;
            h_data[g]  = 8'h00;
        end

        // Reset state
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ss_n",      ss_w[0], 1'b1);
        check("rst_sclk",      sclk_w[0], 1'b0);
        check("rst_mosi",      mosi_w[0], 1'b0);
        check("rst_busy",      o_busy[0], 1'b0);
        check("rst_ready",     o_ready[0], 1'b1);
        check("rst_rsp_valid", o_rsp_valid[0], 1'b0);
        check("rst_rsp_data",  o_rsp_data[0], 8'h00);
        check("rst_ready_d1",  o_ready[1], 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // WR_ADDR 0x3C at CLK_DIV=2: 22 half-periods of 2 clk with ss_n low
        r0 = rsp_cnt[0];
        send(0, WR_ADDR, 8'h3C);
        wait_idle(0);
        check("wra_bits",  frame_bits[0], 10'b00_0011_1100);
        check("wra_len",   last_len[0], 44);
        check("wra_rsp",   rsp_cnt[0] - r0, 0);
        check("wra_guard", guard_run[0], 2);

        // WR_DATA 0xA5 lands in RAM[0x3C]
        send(0, WR_DATA, 8'hA5);
        wait_idle(0);
        check("wrd_bits", frame_bits[0], 10'b01_1010_0101);
        check("wrd_ram",  ram[0][8'h3C], 8'hA5);
        check("wrd_len",  last_len[0], 44);

        // RD_ADDR then RD_DATA: frame grows by (2*1+16)*2 = 36 clk
        send(0, RD_ADDR, 8'h3C);
        wait_idle(0);
        check("rda_bits", frame_bits[0], 10'b10_0011_1100);
        r0 = rsp_cnt[0];
        send(0, RD_DATA, 8'h00);
        wait_idle(0);
        check("rdd_bits",  frame_bits[0], 10'b11_0000_0000);
        check("rdd_len",   last_len[0], 80);
        check("rdd_pulse", rsp_cnt[0] - r0, 1);
        check("rdd_data",  o_rsp_data[0], 8'hA5);

        // Back-to-back with cmd_valid held high for three commands
        @(negedge clk);
        f0 = frames[0];
        h_valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            h_ctrl[0] = b_ctrl[k];
            h_data[0] = b_data[k];
            n = 0;
            while (o_ready[0] !== 1'b1 && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
            check("b2b_accept", n < BUDGET, 1'b1);
            @(posedge clk);
            #1;
        end
        h_valid[0] = 1'b0;
        wait_idle(0);
        check("b2b_frames",   frames[0] - f0, 3);
        check("b2b_ram",      ram[0][8'h11], 8'h5A);
        check("b2b_last",     frame_bits[0], 10'b00_0011_1100);
        check("b2b_gap",      min_high[0], 3);
        check("rsp_hold",     o_rsp_data[0], 8'hA5);
        check("ready_excl0",  ready_viol[0], 0);

        // Reset during bit 5 of WR_DATA 0xFF
        send(0, WR_DATA, 8'hFF);
        n = 0;
        while (rises[0] < 5 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach", n < BUDGET, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_ss_n",  ss_w[0], 1'b1);
        check("mid_sclk",  sclk_w[0], 1'b0);
        check("mid_busy",  o_busy[0], 1'b0);
        check("mid_rsp",   o_rsp_valid[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_ram",   ram[0][8'h3C], 8'hA5);
        send(0, WR_ADDR, 8'h22);
        wait_idle(0);
        check("post_bits", frame_bits[0], 10'b00_0010_0010);
        check("post_len",  last_len[0], 44);
        send(0, WR_DATA, 8'h77);
        wait_idle(0);
        check("post_ram",  ram[0][8'h22], 8'h77);
        check("per0_min",  per_min[0], 4);
        check("per0_max",  per_max[0], 4);
        check("mosi0_stable", mosi_viol[0], 0);

        // CLK_DIV=1 read of 0x81
        send(1, WR_ADDR, 8'h10);
        wait_idle(1);
        send(1, WR_DATA, 8'h81);
        wait_idle(1);
        send(1, RD_ADDR, 8'h10);
        wait_idle(1);
        r0 = rsp_cnt[1];
        send(1, RD_DATA, 8'h00);
        wait_idle(1);
        check("d1_bits",   frame_bits[1], 10'b11_0000_0000);
        check("d1_len",    last_len[1], 40);
        check("d1_pulse",  rsp_cnt[1] - r0, 1);
        check("d1_data",   o_rsp_data[1], 8'h81);
        check("d1_per_min", per_min[1], 2);
        check("d1_per_max", per_max[1], 2);
        check("mosi1_stable", mosi_viol[1], 0);
        check("ready_excl1",  ready_viol[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master (mode 0) that drives the SPI slave / single-port RAM subsystem. It turns one host command (2-bit control plus 8-bit payload) into one SS_n-framed SPI transaction.
- For RD_DATA commands it also receives the 8-bit read byte on MISO and returns it to the host.
- Sits between a host-side valid/ready command port and the slave pins. It serves as the stimulus/reference master for slave-level verification.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1..255.
- TURN_BITS, 1, idle SCLK periods between the end of a RD_DATA command frame and the first MISO sample bit.
- SS_GUARD, 2, minimum clk cycles SS_n is held high between frames.
- MEM_WIDTH, 8, payload and read-data width (shared_pkg).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in M_IDLE; transfer occurs when cmd_valid && cmd_ready.
- cmd_ctrl  in  2  control_e value, sent first on MOSI.
- cmd_data  in  MEM_WIDTH  payload (address or write data).
- rsp_valid  out  1  one-cycle pulse when rsp_data is valid (RD_DATA only).
- rsp_data  out  MEM_WIDTH  byte captured from MISO; holds until the next RD_DATA completes.
- busy  out  1  high whenever state != M_IDLE.
- sclk  out  1  SPI clock; idles low.
- ss_n  out  1  slave select, active low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

Behaviour:
- Reset (async assert, sync release): state=M_IDLE, sclk=0, ss_n=1, mosi=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=1, all counters cleared.
- Framing: 10-bit shift register sh = {cmd_ctrl, cmd_data}, sent MSB first.
- Mode 0 timing: mosi changes only when sclk falls (or at frame start); miso is sampled on the clk edge where sclk rises.
- Half-period counter div_cnt counts 0..CLK_DIV-1. sclk toggles when div_cnt==CLK_DIV-1 in M_SHIFT, M_TURN and M_RECV; otherwise sclk=0.
- M_IDLE:
  - On handshake, latch sh and ctrl; set ss_n=0 and mosi=cmd_ctrl[1] on the next cycle.
  - Go to M_SETUP.
- M_SETUP:
  - Hold sclk low for one half-period (CLK_DIV cycles), then go to M_SHIFT.
- M_SHIFT:
  - bit_cnt counts 10 rising edges.
  - On each falling edge, shift sh left; mosi=sh[8] (the next bit).
  - After the 10th falling edge:
    - if ctrl==RD_DATA, go to M_TURN;
    - otherwise go to M_HOLD.
- M_TURN:
  - TURN_BITS full SCLK periods; mosi=0; miso ignored.
  - Then go to M_RECV.
- M_RECV:
  - 8 rising edges; rx = {rx[6:0], miso} on each.
  - After the 8th falling edge, go to M_HOLD.
- M_HOLD:
  - sclk=0 for one half-period, then ss_n=1.
  - If the frame was RD_DATA: rsp_data=rx and rsp_valid=1 for exactly this one cycle.
  - Go to M_GUARD.
- M_GUARD:
  - ss_n=1 for SS_GUARD cycles (minimum 1), then go to M_IDLE.
- Frame length (SS_n low time): non-read = (1+20+1)·CLK_DIV clk; RD_DATA adds (2·TURN_BITS+16)·CLK_DIV.
- Command-to-ready latency: frame length + 1 + SS_GUARD cycles.
- cmd_valid while busy: ignored (cmd_ready=0); the host must hold it.
- An invalid-by-sequence command (e.g. RD_DATA without a prior RD_ADDR) is still transmitted; the master does not police the slave protocol.
- Reset mid-frame:
  - Immediately ss_n=1 and sclk=0; no rsp_valid.
  - The partial frame is discarded; the slave sees SS_n rise and returns to its IDLE.
- CLK_DIV=1: sclk toggles every clk cycle; all rules above still hold.

Decomposition:
- shared_pkg additions:
  - typedef enum logic [2:0] master_state_e = {M_IDLE, M_SETUP, M_SHIFT, M_TURN, M_RECV, M_HOLD, M_GUARD};
  - constant FRAME_BITS=10.
  - control_e, MEM_WIDTH and ADDR_SIZE are reused from shared_pkg.
- One natural sub-module: spi_sclk_gen. It holds the div_cnt, sclk register and one-cycle rise/fall strobes, and is enabled by the FSM.

Test Plan:
- WR_ADDR 0x3C, CLK_DIV=2: MOSI sampled at sclk rises reads 00_0011_1100; ss_n low for exactly 44 clk; no rsp_valid; cmd_ready returns after ss_n high for 2 cycles.
- WR_DATA 0xA5 after WR_ADDR 0x3C, with a slave+RAM model: RAM[0x3C]==0xA5; frame bits 01_1010_0101.
- RD_ADDR 0x3C then RD_DATA (payload 0x00), with the slave driving 0xA5: rsp_valid single pulse, rsp_data=0xA5; ss_n low time 44+36=80 clk at CLK_DIV=2, TURN_BITS=1.
- Back-to-back: cmd_valid held high for 3 commands → cmd_ready low throughout each frame; ss_n high ≥ SS_GUARD between frames; no command lost or duplicated.
- rst_n asserted during bit 5 of WR_DATA 0xFF → same-cycle ss_n=1, sclk=0, busy=0; RAM unchanged; next command after release transmits correctly.
- CLK_DIV=1, RD_DATA with MISO=0x81: sclk period 2 clk; rsp_data=0x81; mosi stable at every sclk rising edge.
